// File: rtl/machine_csr.sv
// Machine-mode CSR file and trap responder for the kleine-riscv core.
// Holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause, answers the CSR
// read/write port, applies trap and mret updates from writeback, and
// reports gated interrupt pending lines back to writeback.
// Optional feature macro: MACHINE_CSR_COUNTERS_EN (64-bit mcycle/minstret
// plus read-only cycle/time/instret shadows).
module machine_csr #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] read_address,
    output logic [31:0] read_data,
    input  logic        write_enable,
    input  logic [11:0] write_address,
    input  logic [31:0] write_data,
    input  logic        traped,
    input  logic        mret,
    input  logic        retired,
    input  logic [3:0]  ecause,
    input  logic        interupt,
    input  logic [31:0] ecp,
    input  logic        ext_software,
    input  logic        ext_timer,
    input  logic        ext_external,
    output logic        sip,
    output logic        tip,
    output logic        eip,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_vector
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

    // Interrupt enable/pending bits live at positions 3, 7, 11 (software,
    // timer, external); they are stored packed as [0], [1], [2].
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]  mie_q,          mie_d;
    logic [2:0]  mip_q;
    logic [29:0] mtvec_q,        mtvec_d;
    logic [31:0] mscratch_q,     mscratch_d;
    logic [29:0] mepc_q,         mepc_d;
    logic        mcause_int_q,   mcause_int_d;
    logic [3:0]  mcause_code_q,  mcause_code_d;

    // A trap cancels the CSR write of the instruction it interrupts.
    logic        csr_we;
    logic [2:0]  mie_wbits;
    logic [2:0]  irq_pending;
    logic [31:0] mie_rdata;
    logic [31:0] mip_rdata;
    logic [31:0] counter_rdata;

    assign csr_we = write_enable & ~traped;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_irq
            assign mie_wbits[gi]   = write_data[4*gi+3];
            assign irq_pending[gi] = mip_q[gi] & mie_q[gi] & mstatus_mie_q;
        end
    endgenerate

    assign mie_rdata = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
    assign mip_rdata = {20'd0, mip_q[2], 3'd0, mip_q[1], 3'd0, mip_q[0], 3'd0};

    assign sip         = irq_pending[0];
    assign tip         = irq_pending[1];
    assign eip         = irq_pending[2];
    assign trap_vector = {mtvec_q, 2'b00};
    assign mret_vector = {mepc_q, 2'b00};

    // Next-state for the trap/mret/write-controlled registers (trap > mret > write).
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_int_d   = mcause_int_q;
        mcause_code_d  = mcause_code_q;
        if (csr_we) begin
            case (write_address)
                A_MSTATUS: begin
                    mstatus_mie_d  = write_data[3];
                    mstatus_mpie_d = write_data[7];
                end
                A_MIE:      mie_d      = mie_wbits;
                A_MTVEC:    mtvec_d    = write_data[31:2];
                A_MSCRATCH: mscratch_d = write_data;
                A_MEPC:     mepc_d     = write_data[31:2];
                A_MCAUSE: begin
                    mcause_int_d  = write_data[31];
                    mcause_code_d = write_data[3:0];
                end
                default: ;
            endcase
        end
        if (traped) begin
            mepc_d         = ecp[31:2];
            mcause_int_d   = interupt;
            mcause_code_d  = ecause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // State register; mip samples the level request lines every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 3'd0;
            mip_q          <= 3'd0;
            mtvec_q        <= MTVEC_RESET[31:2];
            mscratch_q     <= 32'd0;
            mepc_q         <= 30'd0;
            mcause_int_q   <= 1'b0;
            mcause_code_q  <= 4'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= {ext_external, ext_timer, ext_software};
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_int_q   <= mcause_int_d;
            mcause_code_q  <= mcause_code_d;
        end
    end

`ifdef MACHINE_CSR_COUNTERS_EN
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        unused_bits;

    assign unused_bits = ^ecp[1:0];

    // A software write to either half replaces it and skips that cycle's increment.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = retired ? minstret_q + 64'd1 : minstret_q;
        if (csr_we && write_address == 12'hB00) mcycle_d = {mcycle_q[63:32], write_data};
        if (csr_we && write_address == 12'hB80) mcycle_d = {write_data, mcycle_q[31:0]};
        if (csr_we && write_address == 12'hB02) minstret_d = {minstret_q[63:32], write_data};
        if (csr_we && write_address == 12'hB82) minstret_d = {write_data, minstret_q[31:0]};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Counter read decode, including the user-level read-only shadows.
    always_comb begin
        case (read_address)
            12'hB00, 12'hC00, 12'hC01: counter_rdata = mcycle_q[31:0];
            12'hB80, 12'hC80, 12'hC81: counter_rdata = mcycle_q[63:32];
            12'hB02, 12'hC02:          counter_rdata = minstret_q[31:0];
            12'hB82, 12'hC82:          counter_rdata = minstret_q[63:32];
            default:                   counter_rdata = 32'd0;
        endcase
    end
`else
    logic unused_bits;

    assign unused_bits   = ^{retired, ecp[1:0]};
    assign counter_rdata = 32'd0;
`endif

    // Combinational CSR read mux; unimplemented addresses fall through to 0.
    always_comb begin
        case (read_address)
            A_MSTATUS:  read_data = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            A_MISA:     read_data = MISA_VALUE;
            A_MIE:      read_data = mie_rdata;
            A_MTVEC:    read_data = {mtvec_q, 2'b00};
            A_MSCRATCH: read_data = mscratch_q;
            A_MEPC:     read_data = {mepc_q, 2'b00};
            A_MCAUSE:   read_data = {mcause_int_q, 27'd0, mcause_code_q};
            A_MIP:      read_data = mip_rdata;
            A_MHARTID:  read_data = HART_ID;
            default:    read_data = counter_rdata;
        endcase
    end

endmodule

// File: tb/tb_machine_csr.sv
// Bench for machine_csr: table of one-cycle stimulus records with expected
// post-edge CSR state, routed through a scoreboard queue, plus hand-written
// sequences for reset override and the optional counters.
module tb_machine_csr;

    localparam logic [31:0] TB_MTVEC = 32'h0000_1003;
    localparam logic [31:0] TB_HART  = 32'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] read_address;
    logic [31:0] read_data;
    logic        write_enable;
    logic [11:0] write_address;
    logic [31:0] write_data;
    logic        traped, mret, retired, interupt;
    logic [3:0]  ecause;
    logic [31:0] ecp;
    logic        ext_software, ext_timer, ext_external;
    logic        sip, tip, eip;
    logic [31:0] trap_vector, mret_vector;

    machine_csr #(.MTVEC_RESET(TB_MTVEC), .HART_ID(TB_HART)) dut (
        .clk(clk), .reset(reset),
        .read_address(read_address), .read_data(read_data),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .traped(traped), .mret(mret), .retired(retired),
        .ecause(ecause), .interupt(interupt), .ecp(ecp),
        .ext_software(ext_software), .ext_timer(ext_timer), .ext_external(ext_external),
        .sip(sip), .tip(tip), .eip(eip),
        .trap_vector(trap_vector), .mret_vector(mret_vector)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        trap;
        logic        ret;
        logic        intr;
        logic [3:0]  ec;
        logic [31:0] pc;
        logic [2:0]  ext;      // {external, timer, software}
        logic [11:0] raddr;
        logic [31:0] exp_rd;
        logic [2:0]  exp_irq;  // {eip, tip, sip}
        logic [31:0] exp_tvec;
        logic [31:0] exp_mretv;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        read_address = addr;
        #1;
        chk(name, read_data, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                                input logic tr, input logic rt, input logic it, input logic [3:0] ec,
                                input logic [31:0] pc, input logic [2:0] ext, input logic [11:0] ra,
                                input logic [31:0] er, input logic [2:0] ei,
                                input logic [31:0] et, input logic [31:0] em);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.trap = tr; v.ret = rt; v.intr = it;
        v.ec = ec; v.pc = pc; v.ext = ext; v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
        v.exp_tvec = et; v.exp_mretv = em;
        return v;
    endfunction

    // Drive one strobe cycle, then read back the post-edge state one cycle later.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        write_enable = v.we; write_address = v.waddr; write_data = v.wdata;
        traped = v.trap; mret = v.ret; interupt = v.intr; ecause = v.ec; ecp = v.pc;
        {ext_external, ext_timer, ext_software} = v.ext;
        read_address = v.raddr;
        sb.push_back(v);
        @(negedge clk);
        write_enable = 1'b0; traped = 1'b0; mret = 1'b0;
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d read_data[%03h]", idx, e.raddr), read_data, e.exp_rd);
        chk($sformatf("v%0d irq", idx), {29'd0, eip, tip, sip}, {29'd0, e.exp_irq});
        chk($sformatf("v%0d trap_vector", idx), trap_vector, e.exp_tvec);
        chk($sformatf("v%0d mret_vector", idx), mret_vector, e.exp_mretv);
        $display("v%0d we=%0b wa=%03h wd=%08h trap=%0b mret=%0b ra=%03h rd=%08h irq=%03b",
                 idx, v.we, v.waddr, v.wdata, v.trap, v.ret, v.raddr, read_data, {eip, tip, sip});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v0, v1;
        // we  waddr  wdata         tr rt it ec    pc            ext     ra     exp_rd        irq     tvec          mretv
        vecs.push_back(mk(1, 12'h304, 32'h80,        0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h304, 32'h80,       3'b000, 32'h1000,     32'h0));
        vecs.push_back(mk(1, 12'h300, 32'h8,         0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h300, 32'h1808,     3'b000, 32'h1000,     32'h0));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b010, 12'h344, 32'h80,       3'b010, 32'h1000,     32'h0));
        vecs.push_back(mk(0, 12'h000, 32'h0,         1, 0, 1, 4'h7, 32'h100, 3'b010, 12'h341, 32'h100,      3'b000, 32'h1000,     32'h100));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b010, 12'h342, 32'h8000_0007,3'b000, 32'h1000,     32'h100));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b010, 12'h300, 32'h1880,     3'b000, 32'h1000,     32'h100));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 1, 0, 4'h0, 32'h0,   3'b010, 12'h300, 32'h1888,     3'b010, 32'h1000,     32'h100));
        vecs.push_back(mk(1, 12'h340, 32'hDEAD,      1, 0, 0, 4'h2, 32'h204, 3'b000, 12'h340, 32'h0,        3'b000, 32'h1000,     32'h204));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h341, 32'h204,      3'b000, 32'h1000,     32'h204));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h342, 32'h2,        3'b000, 32'h1000,     32'h204));
        vecs.push_back(mk(1, 12'h305, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h305, 32'hFFFF_FFFC,3'b000, 32'hFFFF_FFFC,32'h204));
        vecs.push_back(mk(1, 12'h341, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h341, 32'hFFFF_FFFC,3'b000, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        vecs.push_back(mk(1, 12'h301, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h301, 32'h4000_0100,3'b000, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        vecs.push_back(mk(1, 12'h300, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h300, 32'h1888,     3'b000, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        vecs.push_back(mk(1, 12'h304, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h304, 32'h888,      3'b000, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b111, 12'h344, 32'h888,      3'b111, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        vecs.push_back(mk(1, 12'h300, 32'h0,         0, 1, 0, 4'h0, 32'h0,   3'b111, 12'h300, 32'h1888,     3'b111, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        vecs.push_back(mk(1, 12'h340, 32'h1234,      0, 1, 0, 4'h0, 32'h0,   3'b111, 12'h340, 32'h1234,     3'b111, 32'hFFFF_FFFC,32'hFFFF_FFFC));
        vecs.push_back(mk(0, 12'h000, 32'h0,         1, 1, 1, 4'hB, 32'h300, 3'b111, 12'h300, 32'h1880,     3'b000, 32'hFFFF_FFFC,32'h300));
        vecs.push_back(mk(0, 12'h000, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b111, 12'h342, 32'h8000_000B,3'b000, 32'hFFFF_FFFC,32'h300));
        vecs.push_back(mk(1, 12'hF14, 32'h5,         0, 0, 0, 4'h0, 32'h0,   3'b000, 12'hF14, 32'h3,        3'b000, 32'hFFFF_FFFC,32'h300));
        vecs.push_back(mk(1, 12'hF11, 32'h1,         0, 0, 0, 4'h0, 32'h0,   3'b000, 12'hF11, 32'h0,        3'b000, 32'hFFFF_FFFC,32'h300));
        vecs.push_back(mk(1, 12'h343, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h343, 32'h0,        3'b000, 32'hFFFF_FFFC,32'h300));
        vecs.push_back(mk(1, 12'h7C0, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h7C0, 32'h0,        3'b000, 32'hFFFF_FFFC,32'h300));
        vecs.push_back(mk(1, 12'h344, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h344, 32'h0,        3'b000, 32'hFFFF_FFFC,32'h300));
        vecs.push_back(mk(1, 12'h300, 32'h0,         0, 0, 0, 4'h0, 32'h0,   3'b000, 12'h300, 32'h1800,     3'b000, 32'hFFFF_FFFC,32'h300));

        reset = 1'b1; read_address = 12'h300;
        write_enable = 1'b0; write_address = 12'h0; write_data = 32'h0;
        traped = 1'b0; mret = 1'b0; retired = 1'b0; interupt = 1'b0; ecause = 4'h0; ecp = 32'h0;
        ext_software = 1'b0; ext_timer = 1'b0; ext_external = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        rd_chk("reset mstatus", 12'h300, 32'h0000_1800);
        rd_chk("reset mtvec", 12'h305, 32'h0000_1000);
        rd_chk("reset mie", 12'h304, 32'h0);
        rd_chk("reset mepc", 12'h341, 32'h0);
        chk("reset irq", {29'd0, eip, tip, sip}, 32'h0);
        chk("reset trap_vector", trap_vector, 32'h0000_1000);
        chk("reset mret_vector", mret_vector, 32'h0);
        $display("reset: mstatus/mtvec/irq/vectors sampled");

        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset wins over a simultaneous trap, mret and CSR write.
        @(negedge clk);
        reset = 1'b1; traped = 1'b1; mret = 1'b1; interupt = 1'b1; ecause = 4'h5; ecp = 32'h444;
        write_enable = 1'b1; write_address = 12'h340; write_data = 32'h77;
        {ext_external, ext_timer, ext_software} = 3'b111;
        @(negedge clk);
        rd_chk("rst-override mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rst-override mscratch", 12'h340, 32'h0);
        rd_chk("rst-override mepc", 12'h341, 32'h0);
        rd_chk("rst-override mcause", 12'h342, 32'h0);
        rd_chk("rst-override mip", 12'h344, 32'h0);
        chk("rst-override trap_vector", trap_vector, 32'h0000_1000);
        $display("reset override: trap+mret+write with reset asserted");
        reset = 1'b0; traped = 1'b0; mret = 1'b0; write_enable = 1'b0;
        {ext_external, ext_timer, ext_software} = 3'b000;
        @(negedge clk);

`ifdef MACHINE_CSR_COUNTERS_EN
        // mcycle low-half carry into the high half.
        write_enable = 1'b1; write_address = 12'hB00; write_data = 32'hFFFF_FFFF;
        @(negedge clk);
        write_address = 12'hB80; write_data = 32'h0;
        @(negedge clk);
        write_enable = 1'b0;
        rd_chk("mcycle after writes", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycleh after writes", 12'hB80, 32'h0);
        @(negedge clk);
        rd_chk("mcycleh carry", 12'hB80, 32'h1);
        rd_chk("cycleh shadow", 12'hC80, 32'h1);
        rd_chk("mcycle wrapped", 12'hB00, 32'h0);
        $display("mcycle carry: low write 0xFFFFFFFF, high write 0");
        // minstret advances exactly once per retired cycle.
        read_address = 12'hB02; #1; v0 = read_data;
        retired = 1'b1;
        repeat (5) @(negedge clk);
        retired = 1'b0;
        read_address = 12'hB02; #1; v1 = read_data;
        chk("minstret +5", v1 - v0, 32'd5);
        rd_chk("instret shadow", 12'hC02, v0 + 32'd5);
        @(negedge clk);
        rd_chk("minstret idle", 12'hB02, v0 + 32'd5);
        $display("minstret: %0d -> %0d over 5 retired cycles", v0, v1);
`else
        write_enable = 1'b1; write_address = 12'hB00; write_data = 32'h1234;
        retired = 1'b1;
        @(negedge clk);
        write_enable = 1'b0; retired = 1'b0;
        @(negedge clk);
        rd_chk("no-counter mcycle", 12'hB00, 32'h0);
        rd_chk("no-counter mcycleh", 12'hB80, 32'h0);
        rd_chk("no-counter cycle", 12'hC00, 32'h0);
        rd_chk("no-counter instret", 12'hC02, 32'h0);
        $display("counters absent: counter addresses read 0");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
